csel_pipe_adder: RTL and testbench
==================================

// Module: csel_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-select add/subtract unit; next generation of the 4-bit carry-select adder.
//  Splits WIDTH into BLOCK_W-bit carry-select blocks, groups STAGE_BLOCKS blocks per pipeline stage.
//  Operands enter and results leave through valid/ready handshakes; sits between operand regs and result bus.
// PARAMETERS
//  WIDTH         16  operand/sum width; must be a multiple of BLOCK_W*STAGE_BLOCKS
//  BLOCK_W        4  bits per carry-select block (dual ripple chains, cin=0 and cin=1, muxed by block carry-in)
//  STAGE_BLOCKS   2  blocks evaluated per pipeline stage; NSTAGE = WIDTH/(BLOCK_W*STAGE_BLOCKS)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: sum=a+b+cin; 1: sum=a-b-cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      add: carry-out; sub: borrow-out (=~internal carry)
//  ovf        out  1      [CSA_OVF_EN only] signed two's-complement overflow of this result
// BEHAVIOUR
//  - Sub mapping: internal B' = b ^ {WIDTH{sub}}, carry-in c0 = cin ^ sub; so sub computes a + ~b + ~cin.
//  - Stage k (0..NSTAGE-1) resolves bits [k*SB*BLOCK_W +: SB*BLOCK_W] from carry registered by stage k-1;
//    stage 0 uses c0. Inside a stage block carries ripple through the select muxes (no registers).
//  - Unresolved upper operand bits are skewed forward by registers; resolved lower sum bits are deskewed,
//    so all sum bits, cout and ovf of one beat appear together.
//  - Pipeline advance: adv = ~out_valid | out_ready; in_ready = adv & ~rst. All stages shift on adv;
//    when !adv every stage holds (data and valid). Beat accepted when in_valid & in_ready.
//  - Latency: NSTAGE cycles from acceptance to out_valid with out_ready held high; throughput 1 beat/cycle;
//    bubbles (in_valid=0) propagate as invalid stages. Order strictly preserved, no loss or duplication.
//  - out_valid, sum, cout, ovf remain stable while out_valid & !out_ready.
//  - Reset: every stage valid=0, all data regs 0; out_valid=0, sum=0, cout=0, ovf=0 the cycle after rst
//    sampled high. in_ready=0 while rst high, 1 in first cycle after release. Reset mid-stream discards
//    all in-flight beats; inputs presented during rst are ignored.
//  - Boundaries: all-ones + 1 wraps to 0 with cout=1; carry crossing block and stage boundaries exact;
//    NSTAGE=1 degenerates to single-cycle registered adder with same handshake.
// CONFIGURATION
//  - CSA_OVF_EN defined: ovf port present; ovf = (a_msb ^ sum_msb) & (b'_msb ^ sum_msb) ... computed as
//    carry-into-MSB ^ carry-out-of-MSB, pipelined aligned with sum; reset 0.
//  - CSA_OVF_EN undefined: ovf port and its registers absent; all other behaviour identical.
// STRUCTURE
//  - Package csel_pkg: localparam functions for NSTAGE and stage slice width, op encoding constants
//    (OP_ADD=1'b0, OP_SUB=1'b1).
//  - One sub-module csel_block: combinational BLOCK_W-bit carry-select block (ports a, b, ci, s, co, c_msb_in);
//    top instantiates WIDTH/BLOCK_W of them and owns all pipeline/skew/deskew registers and handshake.
// TESTING (WIDTH=16, BLOCK_W=4, STAGE_BLOCKS=2 -> NSTAGE=2; plus a WIDTH=32, STAGE_BLOCKS=1 regression)
//  1. rst high 2 cycles -> out_valid=0, sum=0, cout=0, in_ready=0; release -> in_ready=1 next cycle.
//  2. a=FFFF b=0001 cin=0 sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0000, cout=1, ovf=0.
//  3. a=000F b=0000 cin=1 sub=0 -> sum=0010, cout=0 (carry across block boundary from cin).
//  4. a=0005 b=0007 cin=0 sub=1 -> sum=FFFE, cout=1 (borrow); a=7FFF b=0001 add -> sum=8000, ovf=1.
//  5. 8 back-to-back random beats, out_ready toggling 1,0,0,1,... -> 8 results in order vs model,
//     outputs stable during stall, in_ready low exactly when out_valid & !out_ready.
//  6. 3 beats in flight, assert rst 1 cycle -> out_valid=0 next cycle, no stale beat ever emerges.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared constants and sizing helpers for the pipelined carry-select add/subtract unit.
package csel_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int csel_slice_w(input int block_w, input int stage_blocks);
      return block_w * stage_blocks;
   endfunction

   function automatic int csel_nstage(input int width, input int block_w, input int stage_blocks);
      return width / (block_w * stage_blocks);
   endfunction

endpackage

// File: rtl/csel_block.sv
// Combinational carry-select block: two ripple chains (carry-in 0 and 1) selected by the real carry-in.
module csel_block
   import csel_pkg::*;
#(
   parameter int BLOCK_W = 4
) (
   input  logic [BLOCK_W-1:0] a,
   input  logic [BLOCK_W-1:0] b,
   input  logic               ci,
   output logic [BLOCK_W-1:0] s,
   output logic               co,
   output logic               c_msb_in
);

   logic [BLOCK_W:0]   r0, r1;
   logic [BLOCK_W-1:0] s0, s1;

   always_comb begin
      r0    = '0;
      r1    = '0;
      s0    = '0;
      s1    = '0;
      r1[0] = 1'b1;
      for (int i = 0; i < BLOCK_W; i++) begin
         s0[i]   = a[i] ^ b[i] ^ r0[i];
         r0[i+1] = (a[i] & b[i]) | (r0[i] & (a[i] ^ b[i]));
         s1[i]   = a[i] ^ b[i] ^ r1[i];
         r1[i+1] = (a[i] & b[i]) | (r1[i] & (a[i] ^ b[i]));
      end
   end

   assign s        = ci ? s1 : s0;
   assign co       = ci ? r1[BLOCK_W] : r0[BLOCK_W];
   assign c_msb_in = ci ? r1[BLOCK_W-1] : r0[BLOCK_W-1];

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select add/subtract with valid/ready on both sides.
// Optional signed-overflow output enabled by defining CSA_OVF_EN.
module csel_pipe_adder
   import csel_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int BLOCK_W      = 4,
   parameter int STAGE_BLOCKS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CSA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SW     = csel_slice_w(BLOCK_W, STAGE_BLOCKS);
   localparam int NSTAGE = csel_nstage(WIDTH, BLOCK_W, STAGE_BLOCKS);

   logic              adv;
   logic [WIDTH-1:0]  bx;
   logic              c0;
   logic [NSTAGE-1:0] vld_q, vld_d;
`ifdef CSA_OVF_EN
   logic              msb_ci;
`endif

   assign out_valid = vld_q[NSTAGE-1];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv & ~rst;

   // Subtract is a + ~b + ~cin; the final carry is inverted into a borrow at the output.
   assign bx = b ^ {WIDTH{sub == OP_SUB}};
   assign c0 = cin ^ (sub == OP_SUB);

   always_comb begin
      vld_d = vld_q;
      if (adv) begin
         vld_d    = vld_q << 1;
         vld_d[0] = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
      localparam int UW = WIDTH - k*SW;
      localparam int LW = (k+1)*SW;

      logic [UW-1:0]         op_a, op_b;
      logic                  op_sub, ci;
      wire  [STAGE_BLOCKS:0] cc;
      wire  [SW-1:0]         s_slice;
      logic [LW-1:0]         s_d, s_q;

      // Stage input: raw operands for stage 0, skewed upper operands afterwards.
      if (k == 0) begin : g_in
         assign op_a   = a;
         assign op_b   = bx;
         assign ci     = c0;
         assign op_sub = sub;
         assign s_d    = s_slice;
      end else begin : g_in
         assign op_a   = g_stg[k-1].g_mid.ua_q;
         assign op_b   = g_stg[k-1].g_mid.ub_q;
         assign ci     = g_stg[k-1].g_mid.c_q;
         assign op_sub = g_stg[k-1].g_mid.sub_q;
         assign s_d    = {s_slice, g_stg[k-1].s_q};
      end

      assign cc[0] = ci;

      for (genvar j = 0; j < STAGE_BLOCKS; j++) begin : g_blk
`ifdef CSA_OVF_EN
         if (k == NSTAGE-1 && j == STAGE_BLOCKS-1) begin : g_inst
            csel_block #(.BLOCK_W(BLOCK_W)) u_blk (
               .a        (op_a[j*BLOCK_W +: BLOCK_W]),
               .b        (op_b[j*BLOCK_W +: BLOCK_W]),
               .ci       (cc[j]),
               .s        (s_slice[j*BLOCK_W +: BLOCK_W]),
               .co       (cc[j+1]),
               .c_msb_in (msb_ci)
            );
         end else
`endif
         begin : g_inst
            logic cm_unused;
            csel_block #(.BLOCK_W(BLOCK_W)) u_blk (
               .a        (op_a[j*BLOCK_W +: BLOCK_W]),
               .b        (op_b[j*BLOCK_W +: BLOCK_W]),
               .ci       (cc[j]),
               .s        (s_slice[j*BLOCK_W +: BLOCK_W]),
               .co       (cc[j+1]),
               .c_msb_in (cm_unused)
            );
         end
      end

      always_ff @(posedge clk) begin
         if (rst)      s_q <= '0;
         else if (adv) s_q <= s_d;
      end

      // Stage boundary: carry and not-yet-resolved operand bits move on to stage k+1.
      if (k < NSTAGE-1) begin : g_mid
         logic [UW-SW-1:0] ua_q, ub_q;
         logic             c_q, sub_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               ua_q  <= '0;
               ub_q  <= '0;
               c_q   <= 1'b0;
               sub_q <= 1'b0;
            end else if (adv) begin
               ua_q  <= op_a[UW-1:SW];
               ub_q  <= op_b[UW-1:SW];
               c_q   <= cc[STAGE_BLOCKS];
               sub_q <= op_sub;
            end
         end
      end else begin : g_last
         logic co_q;
`ifdef CSA_OVF_EN
         logic ovf_q;
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               co_q  <= 1'b0;
`ifdef CSA_OVF_EN
               ovf_q <= 1'b0;
`endif
            end else if (adv) begin
               co_q  <= cc[STAGE_BLOCKS] ^ (op_sub == OP_SUB);
`ifdef CSA_OVF_EN
               ovf_q <= msb_ci ^ cc[STAGE_BLOCKS];
`endif
            end
         end
      end
   end

   assign sum  = g_stg[NSTAGE-1].s_q;
   assign cout = g_stg[NSTAGE-1].g_last.co_q;
`ifdef CSA_OVF_EN
   assign ovf  = g_stg[NSTAGE-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Scoreboard bench for csel_pipe_adder: 16-bit/2-stage main instance plus a 32-bit/8-stage instance.
module tb_csel_pipe_adder;
   import csel_pkg::*;

   localparam int W   = 16;
   localparam int W2  = 32;
   localparam int NST = csel_nstage(16, 4, 2);

   typedef struct packed {
      logic        ovf;
      logic        cout;
      logic [31:0] sum;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic [W-1:0]  a = '0, b = '0;
   logic          in_ready, out_valid, cout;
   logic [W-1:0]  sum;
   logic          rst2 = 1'b1, in_valid2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0, out_ready2 = 1'b1;
   logic [W2-1:0] a2 = '0, b2 = '0;
   logic          in_ready2, out_valid2, cout2;
   logic [W2-1:0] sum2;
`ifdef CSA_OVF_EN
   logic          ovf, ovf2;
`endif

   csel_pipe_adder #(.WIDTH(W), .BLOCK_W(4), .STAGE_BLOCKS(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CSA_OVF_EN
      , .ovf(ovf)
`endif
   );

   csel_pipe_adder #(.WIDTH(W2), .BLOCK_W(4), .STAGE_BLOCKS(1)) u_dut32 (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
      .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
`ifdef CSA_OVF_EN
      , .ovf(ovf2)
`endif
   );

   int   n_cmp = 0, n_fail = 0;
   exp_t qa[$], qb[$];
   exp_t ea, eb;
   int   rdy_mode = 0, pat = 0;
   logic mon_en = 1'b0, stall_prev = 1'b0;
   logic [W+1:0] held = '0;

   // Reference: plain integer arithmetic on the operands as numbers.
   function automatic exp_t model(input int w, input longint ua, input longint ub, input logic c, input logic s);
      longint half, full, sa, sb, sres, ci;
      exp_t   e;
      ci   = 0;
      ci   = ci + c;
      half = longint'(1) << (w - 1);
      if (s == OP_SUB) begin
         full   = ua - ub - ci;
         e.cout = (full < 0);
      end else begin
         full   = ua + ub + ci;
         e.cout = (full >= 2*half);
      end
      e.sum = 32'(full & (2*half - 1));
      sa    = (ua >= half) ? ua - 2*half : ua;
      sb    = (ub >= half) ? ub - 2*half : ub;
      sres  = (s == OP_SUB) ? sa - sb - ci : sa + sb + ci;
      e.ovf = (sres >= half) || (sres < -half);
      return e;
   endfunction

   function automatic void chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void stray(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: output beat with empty scoreboard", name);
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       begin out_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
      out_ready2 = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst && out_valid && out_ready) begin
            if (qa.size() == 0) stray("beat16");
            else begin
               ea = qa.pop_front();
               chk("beat16_cout_sum", {cout, sum}, {ea.cout, ea.sum[W-1:0]});
`ifdef CSA_OVF_EN
               chk("beat16_ovf", ovf, ea.ovf);
`endif
            end
         end
         if (stall_prev) chk("stall_hold", {out_valid, cout, sum}, held);
         stall_prev = !rst && out_valid && !out_ready;
         held       = {out_valid, cout, sum};
         chk("in_ready_rule", in_ready, !rst && !(out_valid && !out_ready));
      end
   end

   always @(negedge clk) begin
      if (mon_en && !rst2 && out_valid2 && out_ready2) begin
         if (qb.size() == 0) stray("beat32");
         else begin
            eb = qb.pop_front();
            chk("beat32_cout_sum", {cout2, sum2}, {eb.cout, eb.sum});
`ifdef CSA_OVF_EN
            chk("beat32_ovf", ovf2, eb.ovf);
`endif
         end
      end
   end

   task automatic send_a(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs);
      int t;
      a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin qa.push_back(model(W, xa, xb, xc, xs)); break; end
         if (++t > 200) begin n_cmp++; n_fail++; $display("FAIL send16: in_ready stuck 0, required 1"); break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [W2-1:0] xa, input logic [W2-1:0] xb, input logic xc, input logic xs);
      int t;
      a2 = xa; b2 = xb; cin2 = xc; sub2 = xs; in_valid2 = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready2) begin qb.push_back(model(W2, xa, xb, xc, xs)); break; end
         if (++t > 200) begin n_cmp++; n_fail++; $display("FAIL send32: in_ready stuck 0, required 1"); break; end
      end
      @(posedge clk); #1;
      in_valid2 = 1'b0;
   endtask

   task automatic drain(input int which);
      int t;
      t = 0;
      while (((which == 0) ? qa.size() : qb.size()) != 0 && t < 400) begin @(negedge clk); t++; end
      chk((which == 0) ? "drain16_left" : "drain32_left", (which == 0) ? qa.size() : qb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset held for two edges.
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_in_ready", in_ready, 0);
`ifdef CSA_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);
      @(posedge clk); #1;

      // Wrap with latency check.
      send_a(16'hFFFF, 16'h0001, 1'b0, OP_ADD);
      for (int i = 0; i < NST - 1; i++) begin
         @(negedge clk);
         chk("latency_early", out_valid, 0);
      end
      @(negedge clk);
      chk("latency_due", out_valid, 1);
      @(posedge clk); #1;
      drain(0);

      // Directed carry/borrow/overflow corners.
      send_a(16'h000F, 16'h0000, 1'b1, OP_ADD);
      send_a(16'h0005, 16'h0007, 1'b0, OP_SUB);
      send_a(16'h7FFF, 16'h0001, 1'b0, OP_ADD);
      send_a(16'h00FF, 16'h0001, 1'b0, OP_ADD);
      send_a(16'h8000, 16'h0001, 1'b0, OP_SUB);
      send_a(16'h0000, 16'h0000, 1'b1, OP_SUB);
      send_a(16'hFFFF, 16'hFFFF, 1'b1, OP_ADD);
      drain(0);

      // Back-to-back random beats under a 1,0,0,1 ready pattern.
      rdy_mode = 1;
      for (int i = 0; i < 8; i++)
         send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      drain(0);

      // Random beats with bubbles and random ready.
      rdy_mode = 2;
      for (int i = 0; i < 30; i++) begin
         send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rdy_mode = 0;
      drain(0);

      // Reset with beats in flight: none may emerge afterwards.
      send_a(16'h1111, 16'h2222, 1'b0, OP_ADD);
      send_a(16'h3333, 16'h4444, 1'b0, OP_ADD);
      send_a(16'h5555, 16'h6666, 1'b0, OP_ADD);
      rst = 1'b1;
      @(posedge clk); #1;
      qa.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_cout", cout, 0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      send_a(16'hABCD, 16'h1234, 1'b1, OP_SUB);
      send_a(16'h0FFF, 16'h0001, 1'b0, OP_ADD);
      drain(0);

      // 32-bit, one block per stage.
      rst2 = 1'b0;
      send_b(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
      send_b(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
      send_b(32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB);
      for (int i = 0; i < 30; i++)
         send_b($urandom, $urandom, 1'($urandom), 1'($urandom));
      drain(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
